dense_layer: RTL and testbench

Fully-connected layer sequencer on the CPU's Avalon bus, one stage downstream of the single dot-product engine. For each of N output neurons it reads a bias and a weight row from SDRAM and the shared input activations from SRAM. It forms bias + Σ(w·x) in Q16.16, optionally applies ReLU, and writes the result back to SRAM as the next layer's input activations. The CPU writes the configuration, starts the layer, and then stalls on `slave_waitrequest` until the layer is complete.

---
 rtl/dense_layer_pkg.sv | 29 ++
 rtl/dense_layer_q16_mac.sv | 24 ++
 rtl/dense_layer.sv | 214 +++++++++++++++++++++
 tb/tb_dense_layer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_layer_pkg.sv
// Shared types and constants for the dense_layer sequencer and its Q16.16 MAC.
package dense_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS_RD,
        S_BIAS_WT,
        S_EL_RD,
        S_EL_WT,
        S_EL_ACC,
        S_OUT_WR
    } state_t;

    localparam logic [3:0] REG_START  = 4'd0;
    localparam logic [3:0] REG_BIAS   = 4'd1;
    localparam logic [3:0] REG_WEIGHT = 4'd2;
    localparam logic [3:0] REG_INPUT  = 4'd3;
    localparam logic [3:0] REG_OUTPUT = 4'd4;
    localparam logic [3:0] REG_M      = 4'd5;
    localparam logic [3:0] REG_N      = 4'd6;
    localparam logic [3:0] REG_RELU   = 4'd7;

    localparam int FRAC_BITS = 16;

    function automatic logic [31:0] relu_fn(input logic en, input logic [31:0] v);
        return (en && v[31]) ? 32'd0 : v;
    endfunction

endpackage

// File: rtl/dense_layer_q16_mac.sv
// Combinational Q16.16 multiply-accumulate: sum = acc + (a*b)[47:16], wrapping.
module q16_mac
    import dense_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] acc,
    output logic [31:0] sum
);

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] prod;
    logic               unused_prod_bits;

    assign a_ext = {{32{a[31]}}, a};
    assign b_ext = {{32{b[31]}}, b};
    assign prod  = a_ext * b_ext;
    assign sum   = acc + prod[FRAC_BITS+31:FRAC_BITS];

    // Integer overflow bits and sub-LSB fraction bits are discarded by design.
    assign unused_prod_bits = ^{prod[63:FRAC_BITS+32], prod[FRAC_BITS-1:0]};

endmodule

// File: rtl/dense_layer.sv
// Fully-connected layer sequencer: y_j = bias_j + sum_i w(j,i)*x_i in Q16.16,
// weights/biases from the SDRAM master, activations in/out via the SRAM master.
module dense_layer
    import dense_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata,
    input  logic        master2_waitrequest,
    output logic [31:0] master2_address,
    output logic        master2_read,
    input  logic [31:0] master2_readdata,
    input  logic        master2_readdatavalid,
    output logic        master2_write,
    output logic [31:0] master2_writedata
);

    state_t      state;
    logic [31:0] bias_base, weight_base, input_base, output_base;
    logic [31:0] num_in, num_out;
    logic        relu_en;
    logic [31:0] acc, i_idx, j_idx, last_y, w_ptr;
    logic [31:0] w_data, x_data;
    logic        w_have, x_have;
    logic [31:0] mac_sum, i_next, j_next;
    logic        in_el, cap_w, cap_x;

    q16_mac u_mac (
        .a   (w_data),
        .b   (x_data),
        .acc (acc),
        .sum (mac_sum)
    );

    assign i_next = i_idx + 32'd1;
    assign j_next = j_idx + 32'd1;

    // A read is accepted once its strobe has dropped, so its data may land in EL_RD or EL_WT.
    assign in_el = (state == S_EL_RD) || (state == S_EL_WT);
    assign cap_w = in_el && master_readdatavalid && !master_read && !w_have;
    assign cap_x = in_el && master2_readdatavalid && !master2_read && !x_have;

    assign slave_waitrequest = (state != S_IDLE);
    assign master_write      = 1'b0;
    assign master_writedata  = 32'd0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        slave_readdata = 32'd0;
        if (slave_read) begin
            case (slave_address)
                REG_START:  slave_readdata = last_y;
                REG_BIAS:   slave_readdata = bias_base;
                REG_WEIGHT: slave_readdata = weight_base;
                REG_INPUT:  slave_readdata = input_base;
                REG_OUTPUT: slave_readdata = output_base;
                REG_M:      slave_readdata = num_in;
                REG_N:      slave_readdata = num_out;
                REG_RELU:   slave_readdata = {31'd0, relu_en};
                default:    slave_readdata = 32'd0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            bias_base         <= 32'd0;
            weight_base       <= 32'd0;
            input_base        <= 32'd0;
            output_base       <= 32'd0;
            num_in            <= 32'd0;
            num_out           <= 32'd0;
            relu_en           <= 1'b0;
            acc               <= 32'd0;
            i_idx             <= 32'd0;
            j_idx             <= 32'd0;
            last_y            <= 32'd0;
            w_ptr             <= 32'd0;
            w_data            <= 32'd0;
            x_data            <= 32'd0;
            w_have            <= 1'b0;
            x_have            <= 1'b0;
            master_read       <= 1'b0;
            master_address    <= 32'd0;
            master2_read      <= 1'b0;
            master2_address   <= 32'd0;
            master2_write     <= 1'b0;
            master2_writedata <= 32'd0;
        end else begin
            if (cap_w) begin
                w_data <= master_readdata;
                w_have <= 1'b1;
            end
            if (cap_x) begin
                x_data <= master2_readdata;
                x_have <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (slave_write) begin
                        case (slave_address)
                            REG_START: begin
                                j_idx  <= 32'd0;
                                last_y <= 32'd0;
                                w_ptr  <= weight_base;
                                if (num_out != 32'd0) begin
                                    state          <= S_BIAS_RD;
                                    master_read    <= 1'b1;
                                    master_address <= bias_base;
                                end
                            end
                            REG_BIAS:   bias_base   <= slave_writedata;
                            REG_WEIGHT: weight_base <= slave_writedata;
                            REG_INPUT:  input_base  <= slave_writedata;
                            REG_OUTPUT: output_base <= slave_writedata;
                            REG_M:      num_in      <= slave_writedata;
                            REG_N:      num_out     <= slave_writedata;
                            REG_RELU:   relu_en     <= slave_writedata[0];
                            default: ;
                        endcase
                    end
                end
                S_BIAS_RD: begin
                    if (!master_waitrequest) begin
                        master_read <= 1'b0;
                        state       <= S_BIAS_WT;
                    end
                end
                S_BIAS_WT: begin
                    if (master_readdatavalid) begin
                        acc   <= master_readdata;
                        i_idx <= 32'd0;
                        if (num_in == 32'd0) begin
                            state             <= S_OUT_WR;
                            master2_write     <= 1'b1;
                            master2_address   <= output_base + {j_idx[29:0], 2'b00};
                            master2_writedata <= relu_fn(relu_en, master_readdata);
                        end else begin
                            state           <= S_EL_RD;
                            master_read     <= 1'b1;
                            master_address  <= w_ptr;
                            master2_read    <= 1'b1;
                            master2_address <= input_base;
                            w_have          <= 1'b0;
                            x_have          <= 1'b0;
                        end
                    end
                end
                S_EL_RD: begin
                    if (master_read && !master_waitrequest) begin
                        master_read <= 1'b0;
                        w_ptr       <= w_ptr + 32'd4;
                    end
                    if (master2_read && !master2_waitrequest)
                        master2_read <= 1'b0;
                    if ((!master_read || !master_waitrequest) && (!master2_read || !master2_waitrequest))
                        state <= S_EL_WT;
                end
                S_EL_WT: begin
                    if ((w_have || cap_w) && (x_have || cap_x))
                        state <= S_EL_ACC;
                end
                S_EL_ACC: begin
                    acc   <= mac_sum;
                    i_idx <= i_next;
                    if (i_next == num_in) begin
                        state             <= S_OUT_WR;
                        master2_write     <= 1'b1;
                        master2_address   <= output_base + {j_idx[29:0], 2'b00};
                        master2_writedata <= relu_fn(relu_en, mac_sum);
                    end else begin
                        state           <= S_EL_RD;
                        master_read     <= 1'b1;
                        master_address  <= w_ptr;
                        master2_read    <= 1'b1;
                        master2_address <= input_base + {i_next[29:0], 2'b00};
                        w_have          <= 1'b0;
                        x_have          <= 1'b0;
                    end
                end
                S_OUT_WR: begin
                    if (!master2_waitrequest) begin
                        master2_write <= 1'b0;
                        last_y        <= master2_writedata;
                        j_idx         <= j_next;
                        if (j_next == num_out) begin
                            state <= S_IDLE;
                        end else begin
                            state          <= S_BIAS_RD;
                            master_read    <= 1'b1;
                            master_address <= bias_base + {j_next[29:0], 2'b00};
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer.sv
// Self-checking bench for dense_layer: table of layer configurations, memory models
// with optional random stalls/latency, and a scoreboard of expected output writes.
module tb_dense_layer;

    localparam logic [31:0] BIAS_BASE = 32'h0000_0100;
    localparam logic [31:0] W_BASE    = 32'h0000_1000;
    localparam logic [31:0] IN_BASE   = 32'h0000_0200;
    localparam logic [31:0] OUT_BASE  = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = '0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata = '0;
    logic        master_readdatavalid = 1'b0;
    logic        master_write;
    logic [31:0] master_writedata;
    logic        master2_waitrequest = 1'b0;
    logic [31:0] master2_address;
    logic        master2_read;
    logic [31:0] master2_readdata = '0;
    logic        master2_readdatavalid = 1'b0;
    logic        master2_write;
    logic [31:0] master2_writedata;

    dense_layer dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .slave_waitrequest     (slave_waitrequest),
        .slave_address         (slave_address),
        .slave_read            (slave_read),
        .slave_readdata        (slave_readdata),
        .slave_write           (slave_write),
        .slave_writedata       (slave_writedata),
        .master_waitrequest    (master_waitrequest),
        .master_address        (master_address),
        .master_read           (master_read),
        .master_readdata       (master_readdata),
        .master_readdatavalid  (master_readdatavalid),
        .master_write          (master_write),
        .master_writedata      (master_writedata),
        .master2_waitrequest   (master2_waitrequest),
        .master2_address       (master2_address),
        .master2_read          (master2_read),
        .master2_readdata      (master2_readdata),
        .master2_readdatavalid (master2_readdatavalid),
        .master2_write         (master2_write),
        .master2_writedata     (master2_writedata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        int          n;
        logic        relu;
        int          mode;     // 0: zero-wait, 1: random stalls/latency, 2: fixed long latency
        logic [31:0] b0, b1, w0, w1, x0, x1, y0, y1;
        int          wait_exp; // -1: not checked
        bit          chk_y;
    } vec_t;

    typedef struct { logic [31:0] data; int dly; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } exp_t;

    logic [31:0] sdram [logic [31:0]];
    logic [31:0] sram  [logic [31:0]];
    rsp_t        q1[$];
    rsp_t        q2[$];
    exp_t        sb[$];
    vec_t        vecs[$];

    int n_checks = 0;
    int n_errors = 0;
    int lat_mode = 0;
    int n_rd1 = 0, n_rd2 = 0, n_wr2 = 0, n_clash = 0;
    bit x_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int pick_dly();
        if (lat_mode == 1) return int'($urandom_range(0, 3));
        if (lat_mode == 2) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] mem_rd(input bit is_sram, input logic [31:0] a);
        if (is_sram) return sram.exists(a) ? sram[a] : 32'd0;
        return sdram.exists(a) ? sdram[a] : 32'd0;
    endfunction

    // Golden model: signed 64-bit product, keep bits [47:16], wrap at 32 bits.
    function automatic logic [31:0] golden(input int j, input int m, input logic relu);
        logic [31:0] a;
        longint      p;
        a = mem_rd(1'b0, BIAS_BASE + 32'(4 * j));
        for (int i = 0; i < m; i++) begin
            p = longint'($signed(mem_rd(1'b0, W_BASE + 32'(4 * (m * j + i)))))
              * longint'($signed(mem_rd(1'b1, IN_BASE + 32'(4 * i))));
            a = a + 32'(p >>> 16);
        end
        return (relu && a[31]) ? 32'd0 : a;
    endfunction

    // Memory models: act on the falling edge so the DUT sees stable inputs at the rising edge.
    initial begin
        rsp_t h;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q1.delete();
                q2.delete();
                master_readdatavalid  = 1'b0;
                master2_readdatavalid = 1'b0;
                master_waitrequest    = 1'b0;
                master2_waitrequest   = 1'b0;
            end else begin
                master_readdatavalid  = 1'b0;
                master2_readdatavalid = 1'b0;
                master_readdata       = $urandom();
                master2_readdata      = $urandom();
                if (q1.size() > 0) begin
                    h = q1[0];
                    if (h.dly == 0) begin
                        master_readdatavalid = 1'b1;
                        master_readdata      = h.data;
                        void'(q1.pop_front());
                    end else begin
                        h.dly--;
                        q1[0] = h;
                    end
                end
                if (q2.size() > 0) begin
                    h = q2[0];
                    if (h.dly == 0) begin
                        master2_readdatavalid = 1'b1;
                        master2_readdata      = h.data;
                        void'(q2.pop_front());
                    end else begin
                        h.dly--;
                        q2[0] = h;
                    end
                end
                master_waitrequest  = (lat_mode == 1) && ($urandom_range(0, 2) == 0);
                master2_waitrequest = (lat_mode == 1) && ($urandom_range(0, 2) == 0);
                if ((master_read && master_write) || (master2_read && master2_write))
                    n_clash++;
                if (master_read && !master_waitrequest) begin
                    n_rd1++;
                    q1.push_back('{data: mem_rd(1'b0, master_address), dly: pick_dly()});
                end
                if (master2_read && !master2_waitrequest) begin
                    n_rd2++;
                    x_seen = 1'b1;
                    q2.push_back('{data: mem_rd(1'b1, master2_address), dly: pick_dly()});
                end
                if (master2_write && !master2_waitrequest) begin
                    n_wr2++;
                    sram[master2_address] = master2_writedata;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_write: got addr %h data %h, none expected",
                                 master2_address, master2_writedata);
                    end else begin
                        e = sb.pop_front();
                        check("y_addr", master2_address, e.addr);
                        check("y_data", master2_writedata, e.data);
                    end
                end
            end
        end
    end

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(negedge clk);
        slave_write     = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
        slave_address = a;
        slave_read    = 1'b1;
        #1 d = slave_readdata;
        @(negedge clk);
        slave_read    = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_strobes"}, {28'd0, slave_waitrequest, master_read, master2_read, master2_write}, 32'd0);
        check({tag, "_m_addr"}, master_address, 32'd0);
        check({tag, "_m2_addr"}, master2_address, 32'd0);
        check({tag, "_m2_wdata"}, master2_writedata | master_writedata | {31'd0, master_write}, 32'd0);
    endtask

    task automatic setup_case(input vec_t v, input string tag);
        logic [31:0] rd;
        lat_mode = v.mode;
        sdram.delete();
        sram.delete();
        for (int j = 0; j < v.n; j++)
            sdram[BIAS_BASE + 32'(4 * j)] = (j == 0) ? v.b0 : (j == 1) ? v.b1 : $urandom();
        for (int k = 0; k < v.m * v.n; k++)
            sdram[W_BASE + 32'(4 * k)] = (k == 0) ? v.w0 : (k == 1) ? v.w1 : $urandom();
        for (int i = 0; i < v.m; i++)
            sram[IN_BASE + 32'(4 * i)] = (i == 0) ? v.x0 : (i == 1) ? v.x1 : $urandom();
        cpu_write(4'd1, BIAS_BASE);
        cpu_write(4'd2, W_BASE);
        cpu_write(4'd3, IN_BASE);
        cpu_write(4'd4, OUT_BASE);
        cpu_write(4'd5, 32'(v.m));
        cpu_write(4'd6, 32'(v.n));
        cpu_write(4'd7, {31'd0, v.relu});
        cpu_read(4'd6, rd);
        check({tag, "_reg_n"}, rd, 32'(v.n));
        n_rd1 = 0; n_rd2 = 0; n_wr2 = 0; n_clash = 0;
        sb.delete();
        for (int j = 0; j < v.n; j++)
            sb.push_back('{addr: OUT_BASE + 32'(4 * j), data: golden(j, v.m, v.relu)});
    endtask

    task automatic run_case(input vec_t v, input string tag);
        logic [31:0] rd, last_exp;
        int          cnt;
        setup_case(v, tag);
        last_exp = (v.n > 0) ? golden(v.n - 1, v.m, v.relu) : 32'd0;
        cpu_write(4'd0, 32'd0);
        cnt = 0;
        while (slave_waitrequest && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        check({tag, "_done"}, {31'd0, slave_waitrequest}, 32'd0);
        repeat (3) @(negedge clk);
        if (v.wait_exp >= 0) check({tag, "_wait_cycles"}, 32'(cnt), 32'(v.wait_exp));
        check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
        check({tag, "_m_reads"}, 32'(n_rd1), 32'(v.n * (1 + v.m)));
        check({tag, "_m2_reads"}, 32'(n_rd2), 32'(v.n * v.m));
        check({tag, "_m2_writes"}, 32'(n_wr2), 32'(v.n));
        check({tag, "_strobe_clash"}, 32'(n_clash), 32'd0);
        cpu_read(4'd0, rd);
        check({tag, "_last_y"}, rd, last_exp);
        if (v.chk_y) begin
            check({tag, "_y0"}, mem_rd(1'b1, OUT_BASE), v.y0);
            if (v.n > 1) check({tag, "_y1"}, mem_rd(1'b1, OUT_BASE + 32'd4), v.y1);
        end
    endtask

    function automatic vec_t mk(input int m, input int n, input logic relu, input int mode,
                                input logic [31:0] b0, b1, w0, w1, x0, x1, y0, y1,
                                input int wt, input bit chk);
        vec_t v;
        v.m = m; v.n = n; v.relu = relu; v.mode = mode;
        v.b0 = b0; v.b1 = b1; v.w0 = w0; v.w1 = w1; v.x0 = x0; v.x1 = x1;
        v.y0 = y0; v.y1 = y1; v.wait_exp = wt; v.chk_y = chk;
        return v;
    endfunction

    initial begin
        logic [31:0] rd;
        vec_t        v;
        int          cnt;

        // 1.0 + 2.0*3.0 + 0.5*4.0 = 9.0
        vecs.push_back(mk(2, 1, 1'b0, 0, 32'h0001_0000, 0, 32'h0002_0000, 32'h0000_8000,
                          32'h0003_0000, 32'h0004_0000, 32'h0009_0000, 0, 9, 1'b1));
        // -16.0 + 8.0 = -8.0, clamped by ReLU
        vecs.push_back(mk(2, 1, 1'b1, 0, 32'hFFF0_0000, 0, 32'h0002_0000, 32'h0000_8000,
                          32'h0003_0000, 32'h0004_0000, 32'h0000_0000, 0, 9, 1'b1));
        vecs.push_back(mk(2, 1, 1'b0, 0, 32'hFFF0_0000, 0, 32'h0002_0000, 32'h0000_8000,
                          32'h0003_0000, 32'h0004_0000, 32'hFFF8_0000, 0, 9, 1'b1));
        // 0x7FFF.0 + 1.0*2.0 wraps
        vecs.push_back(mk(1, 1, 1'b0, 0, 32'h7FFF_0000, 0, 32'h0001_0000, 0,
                          32'h0002_0000, 0, 32'h8001_0000, 0, 6, 1'b1));
        // M = 0: outputs are the biases
        vecs.push_back(mk(0, 2, 1'b0, 0, 32'h0005_0000, 32'hFFF9_0000, 0, 0,
                          0, 0, 32'h0005_0000, 32'hFFF9_0000, 6, 1'b1));
        // N = 0: no traffic, never leaves IDLE
        vecs.push_back(mk(2, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0));
        vecs.push_back(mk(3, 3, 1'b0, 1, $urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), 0, 0, -1, 1'b0));
        vecs.push_back(mk(2, 3, 1'b1, 1, $urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), 0, 0, -1, 1'b0));

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        for (int a = 1; a < 8; a++) begin
            cpu_read(4'(a), rd);
            check($sformatf("reset_reg%0d", a), rd, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        cpu_write(4'd9, 32'hFFFF_FFFF);
        cpu_read(4'd9, rd);
        check("unmapped_read", rd, 32'd0);

        for (int k = 0; k < vecs.size(); k++)
            run_case(vecs[k], $sformatf("vec%0d", k));

        // Reset while waiting for element data, then a clean rerun.
        v = vecs[0];
        v.mode = 2;
        setup_case(v, "midrst");
        x_seen = 1'b0;
        cpu_write(4'd0, 32'd0);
        cnt = 0;
        while (!x_seen && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("midrst_el_issued", {31'd0, x_seen}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midrst");
        sb.delete();
        repeat (2) @(negedge clk);
        cpu_read(4'd5, rd);
        check("midrst_reg_m", rd, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_case(vecs[0], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
